// File: rtl/iso4_eval_sequencer.sv
// Hardwired micro-sequencer that walks cryptoprocessor_wrapper_40 through one
// 4-isogeny point evaluation: load operands, run the fixed program, read back and reduce.
module iso4_eval_sequencer #(
  parameter int DATA_W = 40,
  parameter int ADDR_W = 7,
  parameter int CMD_W = 3 + 3 * ADDR_W,
  parameter logic [DATA_W:0] P = 41'd574448099311
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] x_in,
  input  logic [DATA_W-1:0] z_in,
  input  logic [DATA_W-1:0] k1_in,
  input  logic [DATA_W-1:0] k2_in,
  input  logic [DATA_W-1:0] k3_in,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] xo_out,
  output logic [DATA_W-1:0] zo_out,
  output logic              cp_get_output,
  output logic              cp_data_en,
  output logic              cp_ins_in,
  output logic [CMD_W-1:0]  cp_command,
  output logic [DATA_W-1:0] cp_din_1,
  output logic [DATA_W-1:0] cp_din_2,
  input  logic [DATA_W-1:0] cp_dout_1,
  input  logic [DATA_W-1:0] cp_dout_2
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_EXEC,
    S_READ,
    S_DONE
  } state_t;

  state_t            state, state_nx;
  logic [3:0]        step, step_nx;

  logic [DATA_W-1:0] z_q, k1_q, k2_q, k3_q;
  logic [DATA_W-1:0] xo_p1;

  logic              get_nx, data_en_nx, ins_in_nx, busy_nx;
  logic [CMD_W-1:0]  cmd_nx;
  logic [DATA_W-1:0] din_1_nx;
  logic              accept;

  function automatic logic [CMD_W-1:0] mk_cmd(input int ins, input int rd1,
                                              input int rd2, input int wr);
    return {3'(ins), ADDR_W'(rd1), ADDR_W'(rd2), ADDR_W'(wr)};
  endfunction

  // Registers 0..4 hold x, z, K1, K2, K3; 5..8 are scratch; xo ends in 7, zo in 8.
  function automatic logic [CMD_W-1:0] exec_word(input logic [3:0] idx);
    logic [CMD_W-1:0] w;
    case (idx)
      4'd0:    w = mk_cmd(3, 0, 1, 5);
      4'd1:    w = mk_cmd(4, 0, 1, 6);
      4'd2:    w = mk_cmd(5, 5, 3, 7);
      4'd3:    w = mk_cmd(5, 6, 4, 8);
      4'd4:    w = mk_cmd(5, 5, 6, 5);
      4'd5:    w = mk_cmd(5, 5, 2, 5);
      4'd6:    w = mk_cmd(3, 7, 8, 6);
      4'd7:    w = mk_cmd(4, 7, 8, 8);
      4'd8:    w = mk_cmd(5, 6, 6, 6);
      4'd9:    w = mk_cmd(5, 8, 8, 8);
      4'd10:   w = mk_cmd(3, 5, 6, 7);
      4'd11:   w = mk_cmd(4, 8, 5, 5);
      4'd12:   w = mk_cmd(5, 7, 6, 7);
      4'd13:   w = mk_cmd(5, 8, 5, 8);
      default: w = mk_cmd(0, 0, 0, 0);
    endcase
    return w;
  endfunction

  // Both halves are already < P, so one conditional subtract finishes the job.
  function automatic logic [DATA_W-1:0] reduce_mod_p(input logic [DATA_W-1:0] a,
                                                      input logic [DATA_W-1:0] b);
    logic [DATA_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= P) s = s - P;
    return s[DATA_W-1:0];
  endfunction

  assign accept = (state == S_IDLE) && start;

  always_comb begin
    state_nx = state;
    step_nx  = step;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nx = S_LOAD;
          step_nx  = 4'd0;
        end
      end
      S_LOAD: begin
        if (step == 4'd4) begin
          state_nx = S_EXEC;
          step_nx  = 4'd0;
        end else begin
          step_nx = step + 4'd1;
        end
      end
      S_EXEC: begin
        if (step == 4'd13) begin
          state_nx = S_READ;
          step_nx  = 4'd0;
        end else begin
          step_nx = step + 4'd1;
        end
      end
      S_READ: begin
        if (step == 4'd2) begin
          state_nx = S_DONE;
          step_nx  = 4'd0;
        end else begin
          step_nx = step + 4'd1;
        end
      end
      S_DONE: begin
        state_nx = S_IDLE;
        step_nx  = 4'd0;
      end
      default: begin
        state_nx = S_IDLE;
        step_nx  = 4'd0;
      end
    endcase
  end

  // Port values are decoded from the next state so they register in step with it.
  always_comb begin
    get_nx     = 1'b0;
    data_en_nx = 1'b0;
    ins_in_nx  = 1'b0;
    cmd_nx     = '0;
    din_1_nx   = '0;
    busy_nx    = (state_nx == S_LOAD) || (state_nx == S_EXEC) || (state_nx == S_READ);
    case (state_nx)
      S_LOAD: begin
        data_en_nx = 1'b1;
        ins_in_nx  = 1'b1;
        cmd_nx     = mk_cmd(1, 0, 0, int'(step_nx));
        // x is taken straight from the port: step 0 is only reached on the accept edge.
        case (step_nx)
          4'd0:    din_1_nx = x_in;
          4'd1:    din_1_nx = z_q;
          4'd2:    din_1_nx = k1_q;
          4'd3:    din_1_nx = k2_q;
          default: din_1_nx = k3_q;
        endcase
      end
      S_EXEC: begin
        ins_in_nx = 1'b1;
        cmd_nx    = exec_word(step_nx);
      end
      S_READ: begin
        if (step_nx == 4'd0) begin
          get_nx = 1'b1;
          cmd_nx = mk_cmd(0, 7, 0, 0);
        end else if (step_nx == 4'd1) begin
          get_nx = 1'b1;
          cmd_nx = mk_cmd(0, 8, 0, 0);
        end
      end
      default: ;
    endcase
  end

  // Control and port stage
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      step          <= 4'd0;
      busy          <= 1'b0;
      done          <= 1'b0;
      xo_out        <= '0;
      zo_out        <= '0;
      cp_get_output <= 1'b0;
      cp_data_en    <= 1'b0;
      cp_ins_in     <= 1'b0;
      cp_command    <= '0;
      cp_din_1      <= '0;
      cp_din_2      <= '0;
    end else begin
      state         <= state_nx;
      step          <= step_nx;
      busy          <= busy_nx;
      done          <= (state == S_READ) && (step == 4'd2);
      cp_get_output <= get_nx;
      cp_data_en    <= data_en_nx;
      cp_ins_in     <= ins_in_nx;
      cp_command    <= cmd_nx;
      cp_din_1      <= din_1_nx;
      cp_din_2      <= '0;
      if ((state == S_READ) && (step == 4'd2)) begin
        xo_out <= xo_p1;
        zo_out <= reduce_mod_p(cp_dout_1, cp_dout_2);
      end
    end
  end

  // Operand capture and xo holding stage
  always_ff @(posedge clk) begin
    if (accept) begin
      z_q  <= z_in;
      k1_q <= k1_in;
      k2_q <= k2_in;
      k3_q <= k3_in;
    end
    if ((state == S_READ) && (step == 4'd1)) begin
      xo_p1 <= reduce_mod_p(cp_dout_1, cp_dout_2);
    end
  end

endmodule

// File: doc/iso4_eval_sequencer.md
Name: iso4_eval_sequencer

Overview:
- Hardwired micro-sequencer that drives cryptoprocessor_wrapper_40 through one complete 4-isogeny point evaluation.
- Flow: load x, z, K1, K2, K3 into the register file; issue the fixed 14-instruction add/sub/mul program; read back xo and zo and reduce the redundant output pair mod P.
- Sits between the top-level VDF step controller (start/done handshake) and the wrapper's command/data port. It replaces testbench-style command driving.

Parameters:
- DATA_W, 40, field element width.
- ADDR_W, 7, register-file address width.
- CMD_W, 24, command width = 3 + 3*ADDR_W.
- P, 41'd574448099311, field prime used for final output reduction.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a new evaluation; sampled only in IDLE.
- x_in, z_in  input  DATA_W each  projective input point; captured on the start-accept edge.
- k1_in, k2_in, k3_in  input  DATA_W each  4-isogeny constants; captured on the start-accept edge.
- busy  output  1  high from the cycle after accept through the last capture cycle.
- done  output  1  one-cycle pulse; xo_out/zo_out are valid in that cycle.
- xo_out, zo_out  output  DATA_W each  reduced result; held until the next done.
- cp_get_output  output  1  to wrapper get_output.
- cp_data_en  output  1  to wrapper data_en.
- cp_ins_in  output  1  to wrapper ins_in.
- cp_command  output  CMD_W  {INS[2:0], rd1, rd2, wr}.
- cp_din_1, cp_din_2  output  DATA_W each  wrapper data inputs.
- cp_dout_1, cp_dout_2  input  DATA_W each  wrapper redundant output pair.

Behaviour:
- All outputs are registered.
- Reset values: busy=0, done=0, xo_out=0, zo_out=0, all cp_* = 0 (command INS=0, idle).
- Wrapper accepts one command per cycle. Data hazards are resolved inside the wrapper. Read data (dout) is valid in the cycle after the read command is driven.
- FSM states: IDLE -> LOAD -> EXEC -> READ -> DONE -> IDLE. A step counter (0..13) indexes LOAD and EXEC.
- Accept: cycle T with state IDLE and start=1. Inputs are latched into local regs and the FSM goes to LOAD.
- LOAD, cycles T+1..T+5:
  - cp_data_en=1, cp_ins_in=1, INS=1, rd1=rd2=0, cp_din_2=0.
  - (din_1, wr) per cycle: (x,0), (z,1), (k1,2), (k2,3), (k3,4).
- EXEC, cycles T+6..T+19:
  - cp_data_en=0, cp_ins_in=1, cp_din_*=0.
  - Program (INS,rd1,rd2,wr) in order: (3,0,1,5) (4,0,1,6) (5,5,3,7) (5,6,4,8) (5,5,6,5) (5,5,2,5) (3,7,8,6) (4,7,8,8) (5,6,6,6) (5,8,8,8) (3,5,6,7) (4,8,5,5) (5,7,6,7) (5,8,5,8).
  - INS codes: 3=ADD, 4=SUB, 5=MUL.
- READ:
  - T+20: cp_get_output=1, command {0,7,0,0}.
  - T+21: cp_get_output=1, command {0,8,0,0}; xo is captured from dout at the end of T+21.
  - T+22: command idle, cp_get_output=0; zo is captured at the end of T+22.
- Reduction: s = cp_dout_1 + cp_dout_2 at DATA_W+1 bits. Result = (s >= P) ? s - P : s. The wrapper guarantees each dout < P, so a single conditional subtract suffices.
- DONE: T+23, done=1 for one cycle, busy=0. busy is 1 for T+1..T+22. Next state is IDLE.
- Total start-to-done latency: 23 cycles. Minimum accept-to-accept spacing: 24 cycles.
- start while busy, or in the DONE cycle, is ignored (no queueing). Input ports may change freely after the accept edge.
- Outside LOAD, EXEC and READ, cp_* hold the idle values (all zero).
- rst mid-operation: on the next edge the FSM goes to IDLE, the counter goes to 0, cp_* go idle, and busy/done/xo_out/zo_out are cleared. Wrapper RAM contents are don't-care; the next run reloads them.
- rst and start in the same cycle: rst wins and the request is dropped.

Test Plan:
- Golden vector: x=182923969081, z=271521918425, k1=115280973463, k2=256747976770, k3=71588158511 -> done at T+23 with xo_out=70658837294, zo_out=222094701421.
- Command trace: monitor cp_command/cp_data_en/cp_ins_in/cp_get_output during the golden run -> exactly the 5 LOAD, 14 EXEC and 2 READ words listed, on cycles T+1..T+21, idle elsewhere.
- Reduction boundary (stubbed wrapper outputs):
  - dout_1=P-1, dout_2=1 -> 0.
  - dout_1=P-1, dout_2=P-1 -> P-2.
  - dout_1=5, dout_2=0 -> 5.
- start pulsed at T+10 and at T+23 (done cycle) -> both ignored; exactly one done pulse; the next start at T+24 is accepted and done arrives at T+47.
- rst asserted at T+12 -> the cycle after has busy=0 and all cp_* zero, and no done follows. A fresh golden run afterwards returns the same xo/zo.
- start held high continuously for 3 runs -> done at T+23, T+47 and T+71, each with the golden results.
